// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU command sequencer.
// The optional accumulator-chaining feature is enabled with ALU_SEQ_CHAIN_EN.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTR_W  = 4;

  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_AND        = 4'b0010;
  localparam logic [3:0] OP_OR         = 4'b0011;
  localparam logic [3:0] OP_XOR        = 4'b0100;
  localparam logic [3:0] OP_NOT        = 4'b0101;
  localparam logic [3:0] OP_SLL        = 4'b0110;
  localparam logic [3:0] OP_LAST_LEGAL = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: command and response channels of the ALU sequencer.
// master = command initiator / response consumer, slave = the sequencer.
interface alu_seq_ctrl_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_illegal;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
  );

endinterface

// File: rtl/alu_seq_settle_ctr.sv
// alu_seq_settle_ctr: loadable down-counter timing the ALU settle window.
// "last" is high while the count equals 1, i.e. on the final settle cycle.
module alu_seq_settle_ctr
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CTR_W-1:0] count;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CTR_W'(1);
    end
  end

  assign last = (count == CTR_W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-at-a-time command sequencer in front of an external
// 8-bit combinational ALU, with an accumulator of the last legal result.
// Optional feature ALU_SEQ_CHAIN_EN: cmd_use_acc selects acc as operand A.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seq_ctrl_if.slave     bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] acc
);

  localparam logic [CTR_W-1:0] SETTLE_LD = CTR_W'(SETTLE_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              legal;
  logic              load_ops;
  logic              capture;
  logic              settle_last;
  logic [DATA_W-1:0] a_sel;

  assign accept   = bus.cmd_valid && (state == ST_IDLE);
  assign legal    = op_legal(bus.cmd_op);
  assign load_ops = accept && legal;
  assign capture  = (state == ST_DRIVE) && settle_last;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);

  // Operand A source: command operand or, when chaining, the accumulator.
  always_comb begin
    a_sel = bus.cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
    if (bus.cmd_use_acc) begin
      a_sel = acc;
    end
`endif
  end

  alu_seq_settle_ctr u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_ops),
    .load_val (SETTLE_LD),
    .dec      (state == ST_DRIVE),
    .last     (settle_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: illegal opcodes skip DRIVE and respond immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)        state_nxt = legal ? ST_DRIVE : ST_RESP;
      ST_DRIVE: if (settle_last)   state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers, response capture and accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_op          <= '0;
      acc             <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_zero    <= 1'b0;
      bus.rsp_carry   <= 1'b0;
      bus.rsp_illegal <= 1'b0;
    end else begin
      if (load_ops) begin
        alu_a  <= a_sel;
        alu_b  <= bus.cmd_b;
        alu_op <= bus.cmd_op;
      end
      if (accept && !legal) begin
        bus.rsp_result  <= '0;
        bus.rsp_zero    <= 1'b0;
        bus.rsp_carry   <= 1'b0;
        bus.rsp_illegal <= 1'b1;
      end
      if (capture) begin
        bus.rsp_result  <= alu_result;
        bus.rsp_zero    <= alu_zero;
        bus.rsp_carry   <= alu_carry;
        bus.rsp_illegal <= 1'b0;
        acc             <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with two instances
// (SETTLE_CYCLES = 1 and 3), each wired to a behavioural model of the ALU.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic clk;
  logic rst1_n;
  logic rst3_n;

  int unsigned checks;
  int unsigned errors;

  alu_seq_ctrl_if if1 ();
  alu_seq_ctrl_if if3 ();

  logic [7:0] alu_a1, alu_b1, alu_res1, acc1;
  logic [3:0] alu_op1;
  logic       alu_z1, alu_c1;
  logic [7:0] alu_a3, alu_b3, alu_res3, acc3;
  logic [3:0] alu_op3;
  logic       alu_z3, alu_c3;

  // External 8-bit ALU: {zero, carry, result}.
  function automatic logic [9:0] alu_model(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    t = '0;
    case (op)
      OP_ADD:  begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
      OP_SUB:  begin r = a - b; c = (a < b); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SLL:  r = a << b;
      default: r = '0;
    endcase
    return {(r == 8'd0), c, r};
  endfunction

  assign {alu_z1, alu_c1, alu_res1} = alu_model(alu_op1, alu_a1, alu_b1);
  assign {alu_z3, alu_c3, alu_res3} = alu_model(alu_op3, alu_a3, alu_b3);

  alu_seq_ctrl #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .bus(if1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_result(alu_res1), .alu_zero(alu_z1), .alu_carry(alu_c1),
    .acc(acc1)
  );

  alu_seq_ctrl #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .bus(if3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_res3), .alu_zero(alu_z3), .alu_carry(alu_c3),
    .acc(acc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input int unsigned u, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic ua);
    if (u == 1) begin
      if1.cmd_valid = v; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b; if1.cmd_use_acc = ua;
    end else begin
      if3.cmd_valid = v; if3.cmd_op = op; if3.cmd_a = a; if3.cmd_b = b; if3.cmd_use_acc = ua;
    end
  endtask

  function automatic logic rsp_v(input int unsigned u);
    return (u == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction

  // Present a command for one edge (sequencer is idle), then count the edges
  // after the accepting edge until rsp_valid is seen (0 = right after it).
  task automatic issue(input int unsigned u, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ua, output int unsigned lat);
    @(negedge clk);
    drive_cmd(u, 1'b1, op, a, b, ua);
    @(posedge clk);
    #1;
    drive_cmd(u, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    lat = 0;
    while (!rsp_v(u) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_rsp(input int unsigned u);
    if (u == 1) if1.rsp_ready = 1'b1; else if3.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if (u == 1) if1.rsp_ready = 1'b0; else if3.rsp_ready = 1'b0;
  endtask

  initial begin
    int unsigned lat;
    logic        seen;
    checks = 0;
    errors = 0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    drive_cmd(1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    drive_cmd(3, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    if1.rsp_ready = 1'b0;
    if3.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(if1.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
    check("rst_acc",       32'(acc1),          32'd0);
    check("rst_alu_op",    32'(alu_op1),       32'd0);
    check("rst_result",    32'(if1.rsp_result), 32'd0);
    check("rst_illegal",   32'(if1.rsp_illegal), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    // ADD 5+3 with 1-cycle settle.
    issue(1, OP_ADD, 8'd5, 8'd3, 1'b0, lat);
    check("add_lat",    lat, 32'd1);
    check("add_result", 32'(if1.rsp_result), 32'd8);
    check("add_zero",   32'(if1.rsp_zero),   32'd0);
    check("add_carry",  32'(if1.rsp_carry),  32'd0);
    check("add_acc",    32'(acc1),           32'd8);
    check("add_ops",    32'({alu_a1, alu_b1}), 32'h0503);
    take_rsp(1);
    check("add_idle", 32'(if1.cmd_ready), 32'd1);

    // Illegal opcode: immediate response, operands and acc untouched.
    issue(1, 4'b1000, 8'd9, 8'd9, 1'b0, lat);
    check("ill_lat",     lat, 32'd0);
    check("ill_flag",    32'(if1.rsp_illegal), 32'd1);
    check("ill_result",  32'(if1.rsp_result),  32'd0);
    check("ill_flags",   32'({if1.rsp_zero, if1.rsp_carry}), 32'd0);
    check("ill_acc",     32'(acc1),    32'd8);
    check("ill_alu_op",  32'(alu_op1), 32'd0);
    take_rsp(1);

    // ADD overflow.
    issue(1, OP_ADD, 8'd255, 8'd1, 1'b0, lat);
    check("ovf_result",  32'(if1.rsp_result), 32'd0);
    check("ovf_flags",   32'({if1.rsp_zero, if1.rsp_carry}), 32'b11);
    check("ovf_illegal", 32'(if1.rsp_illegal), 32'd0);
    take_rsp(1);

    // SUB with borrow.
    issue(1, OP_SUB, 8'd5, 8'd8, 1'b0, lat);
    check("sub1_result", 32'(if1.rsp_result), 32'd253);
    check("sub1_flags",  32'({if1.rsp_zero, if1.rsp_carry}), 32'b01);
    take_rsp(1);
    issue(1, OP_SUB, 8'd0, 8'd1, 1'b0, lat);
    check("sub2_result", 32'(if1.rsp_result), 32'd255);
    check("sub2_carry",  32'(if1.rsp_carry),  32'd1);
    take_rsp(1);

    // Chained SUB: acc - 8 when chaining is built in, otherwise 0 - 8.
    issue(1, OP_ADD, 8'd5, 8'd3, 1'b0, lat);
    take_rsp(1);
    issue(1, OP_SUB, 8'd0, 8'd8, 1'b1, lat);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_result", 32'(if1.rsp_result), 32'd0);
    check("chain_flags",  32'({if1.rsp_zero, if1.rsp_carry}), 32'b10);
    check("chain_alu_a",  32'(alu_a1), 32'd8);
`else
    check("chain_result", 32'(if1.rsp_result), 32'd248);
    check("chain_flags",  32'({if1.rsp_zero, if1.rsp_carry}), 32'b01);
    check("chain_alu_a",  32'(alu_a1), 32'd0);
`endif
    take_rsp(1);

    // SLL with 3-cycle settle, response back-pressured for 5 cycles while
    // another command is offered and must be ignored.
    issue(3, OP_SLL, 8'hAA, 8'd2, 1'b0, lat);
    check("sll_lat", lat, 32'd3);
    drive_cmd(3, 1'b1, OP_ADD, 8'd1, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("sll_result", 32'(if3.rsp_result), 32'hA8);
      check("sll_hold",   32'({if3.rsp_valid, if3.cmd_ready}), 32'b10);
      @(posedge clk);
      #1;
    end
    check("sll_alu_op", 32'(alu_op3), 32'(OP_SLL));
    drive_cmd(3, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    take_rsp(3);
    check("sll_idle", 32'({if3.rsp_valid, if3.cmd_ready}), 32'b01);

    // Reset in the middle of DRIVE drops the command.
    @(negedge clk);
    drive_cmd(3, 1'b1, OP_SUB, 8'd7, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    drive_cmd(3, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    check("mid_drive_busy", 32'(if3.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst3_n = 1'b0;
    #1;
    check("mrst_ready", 32'({if3.cmd_ready, if3.rsp_valid}), 32'b10);
    check("mrst_alu",   32'({alu_a3, alu_b3, alu_op3}), 32'd0);
    check("mrst_rsp",   32'({if3.rsp_result, if3.rsp_zero, if3.rsp_carry, if3.rsp_illegal}), 32'd0);
    check("mrst_acc",   32'(acc3), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | if3.rsp_valid;
    end
    check("mrst_no_rsp", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer that sits on the initiator side of the team's 8-bit combinational ALU. It accepts one ALU command at a time over a valid/ready handshake, drives the ALU operand and opcode lines from registers, waits a configurable settle time, captures result and flags, and returns them over a valid/ready response channel. It also keeps an 8-bit accumulator so consecutive commands can chain results.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before capture; legal range 1..15.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SLL; 0111..1111 illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B; shift amount for SLL; ignored by the ALU for NOT.
- cmd_use_acc  in  1  take A from the accumulator (see Configuration).
- alu_a, alu_b  out  8  registered operands to the ALU.
- alu_op  out  4  registered opcode to the ALU.
- alu_result  in  8  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry (ADD) / borrow (SUB).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  8  captured result.
- rsp_zero, rsp_carry  out  1  captured flags.
- rsp_illegal  out  1  command had an illegal opcode.
- acc  out  8  current accumulator value.

## Operation
- FSM states: IDLE, DRIVE, RESP. cmd_ready = (state == IDLE); rsp_valid = (state == RESP).
- IDLE: on cmd_valid && cmd_ready:
  - legal op: load alu_a (cmd_a, or acc when chaining), alu_b = cmd_b, alu_op = cmd_op; load settle counter with SETTLE_CYCLES; go to DRIVE.
  - illegal op: alu_* unchanged; rsp_result = 0, rsp_zero = 0, rsp_carry = 0, rsp_illegal = 1; go directly to RESP; acc unchanged.
- DRIVE: counter decrements each cycle; on the edge where the counter is 1, capture alu_result/alu_zero/alu_carry into rsp_*, clear rsp_illegal, write alu_result into acc, go to RESP.
- RESP: rsp_* held stable while rsp_ready is low; on rsp_ready high go to IDLE.
- The sequencer does not compute flags; it forwards the ALU's values unchanged. SUB carry is the borrow (1 when A < B).
- alu_a/alu_b/alu_op hold their last values in IDLE and RESP.
- Reset (any state, including mid-DRIVE): state IDLE, counter 0, acc 0, alu_a/alu_b/alu_op 0, rsp_result 0, rsp_zero 0, rsp_carry 0, rsp_illegal 0. After reset, cmd_ready = 1 and rsp_valid = 0. An in-flight command is dropped with no response.

## Timing
- Legal command accepted at edge E: alu_* valid after E; capture at edge E+SETTLE_CYCLES; rsp_valid high from then.
- Illegal command: rsp_valid high after edge E (1-cycle latency).
- Response handshake at edge R: IDLE after R; next accept no earlier than R+1.
- Best-case legal throughput: one command per SETTLE_CYCLES+2 cycles. Requests never overlap.
- cmd_valid while not in IDLE is ignored; the command must be held until accepted.

## Configuration
- ALU_SEQ_CHAIN_EN defined: cmd_use_acc = 1 selects acc as operand A; cmd_a is ignored.
- ALU_SEQ_CHAIN_EN undefined: cmd_use_acc is ignored and A is always cmd_a. The acc register and port still exist and update.

## Structure
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_SLL), OP_LAST_LEGAL = 4'b0110, FSM state encoding, operand width constant 8.
- One sub-module is natural: alu_seq_settle_ctr. It is a loadable down-counter with an asynchronous active-low reset and a "last" output that is asserted when the count is 1.
- The ALU is not instantiated inside. The bench connects the team's 8-bit ALU to the alu_* ports.

## Test plan
- ADD A=5, B=3, SETTLE_CYCLES=1 -> rsp_result 8, zero 0, carry 0; rsp_valid 1 cycle after accept; acc = 8.
- ADD A=255, B=1 -> rsp_result 0, zero 1, carry 1.
- SUB A=5, B=8 -> rsp_result 253, carry 1; then SUB A=0, B=1 -> 255, carry 1.
- ALU_SEQ_CHAIN_EN: ADD 5,3, then SUB use_acc B=8 -> result 0, zero 1. Same sequence without the macro and cmd_a=0 -> result 248, carry 1.
- Illegal op 4'b1000 after the ADD 5,3 -> rsp_illegal 1, rsp_result 0, acc still 8, alu_op still 0000, response after 1 cycle.
- SETTLE_CYCLES=3, SLL A=0xAA, B=2 with rsp_ready low for 5 cycles -> result 0xA8 held stable and cmd_ready 0 throughout. Separately, assert rst_n low mid-DRIVE -> all outputs 0, cmd_ready 1, no response emitted.
